// File: rtl/btn_pkg.sv
// Shared button-conditioner definitions: FSM state encoding reused by
// other button/LED blocks for state_dbg decoding, plus counter sizing.
package btn_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE       = 3'd0,
    ST_DB_PRESS   = 3'd1,
    ST_HELD       = 3'd2,
    ST_REPEAT     = 3'd3,
    ST_DB_RELEASE = 3'd4
  } btn_state_e;

  // Counter width for a terminal count of n cycles, never below 1 bit.
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for one asynchronous input bit; resets to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Metastability filter chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/btn_conditioner.sv
// Push-button conditioner: synchronise, debounce, and emit one-cycle
// press / release / long-press / auto-repeat pulses plus a stable level.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_250_000,
  parameter int LONG_CYCLES     = 125_000_000,
  parameter int REPEAT_CYCLES   = 25_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_raw,
  output logic               btn_level,
  output logic               press_pulse,
  output logic               release_pulse,
  output logic               long_pulse,
  output logic               repeat_pulse,
  output logic [STATE_W-1:0] state_dbg
);

  localparam int DB_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam int HOLD_W = cnt_width(LONG_CYCLES);
  localparam int REP_W  = cnt_width(REPEAT_CYCLES);

  // The sample that leaves IDLE/HELD/REPEAT counts towards the debounce
  // window, so the debounce counter terminates one step earlier.
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 2);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_err
    $error("btn_conditioner: cycle parameters must all be >= 2");
  end

  logic              btn_s;
  btn_state_e        state_q, state_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
  logic              ret_rep_q, ret_rep_d;
  logic              level_q, level_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              long_q, long_d;
  logic              repeat_q, repeat_d;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_raw),
    .q     (btn_s)
  );

  // State, counters and registered pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      db_cnt_q   <= '0;
      hold_cnt_q <= '0;
      rep_cnt_q  <= '0;
      ret_rep_q  <= 1'b0;
      level_q    <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
      repeat_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      db_cnt_q   <= db_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      rep_cnt_q  <= rep_cnt_d;
      ret_rep_q  <= ret_rep_d;
      level_q    <= level_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
      repeat_q   <= repeat_d;
    end
  end

  // Next-state and pulse decode.
  always_comb begin
    state_d    = state_q;
    db_cnt_d   = db_cnt_q;
    hold_cnt_d = hold_cnt_q;
    rep_cnt_d  = rep_cnt_q;
    ret_rep_d  = ret_rep_q;
    level_d    = level_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;
    repeat_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (btn_s) begin
          state_d  = ST_DB_PRESS;
          db_cnt_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DB_PRESS: begin
        if (!btn_s) begin
          state_d = ST_IDLE;
        end else if (db_cnt_q == DB_LAST) begin
          state_d    = ST_HELD;
          press_d    = 1'b1;
          level_d    = 1'b1;
          hold_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      ST_HELD: begin
        if (!btn_s) begin
          state_d   = ST_DB_RELEASE;
          db_cnt_d  = '0;
          ret_rep_d = 1'b0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d   = ST_REPEAT;
          long_d    = 1'b1;
          rep_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      ST_REPEAT: begin
        if (!btn_s) begin
          state_d   = ST_DB_RELEASE;
          db_cnt_d  = '0;
          ret_rep_d = 1'b1;
        end else if (rep_cnt_q == REP_LAST) begin
          repeat_d  = 1'b1;
          rep_cnt_d = '0;
        end else begin
          rep_cnt_d = rep_cnt_q + REP_W'(1);
        end
      end
      ST_DB_RELEASE: begin
        if (btn_s) begin
          // Glitch rejected: the returning cycle counts, but a terminal
          // count is left for the next cycle so no pulse fires here.
          if (ret_rep_q) begin
            state_d = ST_REPEAT;
            if (rep_cnt_q != REP_LAST) begin
              rep_cnt_d = rep_cnt_q + REP_W'(1);
            end else begin
              rep_cnt_d = rep_cnt_q;
            end
          end else begin
            state_d = ST_HELD;
            if (hold_cnt_q != HOLD_LAST) begin
              hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end else begin
              hold_cnt_d = hold_cnt_q;
            end
          end
        end else if (db_cnt_q == DB_LAST) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
          level_d   = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        level_d = 1'b0;
      end
    endcase
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = repeat_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DEBOUNCE=4, LONG=20, REPEAT=5.
module tb_btn_conditioner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_raw = 1'b0;
  logic       btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;

  btn_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .LONG_CYCLES     (20),
    .REPEAT_CYCLES   (5)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_raw       (btn_raw),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse),
    .repeat_pulse  (repeat_pulse),
    .state_dbg     (state_dbg)
  );

  always #5 clk = ~clk;

  // Observed outputs packed as {level, press, release, long, repeat, state}.
  function automatic logic [7:0] obs();
    return {btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse, state_dbg};
  endfunction

  function automatic logic [7:0] pk(input logic lv, input logic pr, input logic rl,
                                    input logic lg, input logic rp, input logic [2:0] st);
    return {lv, pr, rl, lg, rp, st};
  endfunction

  // Expected outputs after edge k of a hold whose first raw=1 sample is edge 1.
  function automatic logic [7:0] held_profile(input int k);
    logic [2:0] st;
    st = (k < 3) ? 3'd0 : (k < 6) ? 3'd1 : (k < 26) ? 3'd2 : 3'd3;
    return pk(k >= 6, k == 6, 1'b0, k == 26, (k > 26) && ((k - 26) % 5 == 0), st);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] e;
    rst_n   = 1'b0;
    btn_raw = 1'b1;
    repeat (3) tick();
    checks++;
    if (obs() !== 8'h00) begin
      errors++;
      $display("FAIL reset_state got=%b want=%b", obs(), 8'h00);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      e = held_profile(k);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL reset_press k=%0d got=%b want=%b", k, obs(), e);
      end
    end
    btn_raw = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      e = (k < 3) ? pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2) :
          (k < 6) ? pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4) :
                    pk(1'b0, k == 6, 1'b0, 1'b0, 1'b0, 3'd0) | {2'b00, k == 6, 5'b0};
      e[6] = 1'b0;
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL reset_release k=%0d got=%b want=%b", k, obs(), e);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [7:0] e;
    for (int k = 1; k <= 24; k++) begin
      btn_raw = (k <= 12);
      tick();
      if (k <= 14)      e = held_profile(k);
      else if (k < 18)  e = pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4);
      else              e = pk(1'b0, 1'b0, k == 18, 1'b0, 1'b0, 3'd0);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL clean_press k=%0d got=%b want=%b", k, obs(), e);
      end
    end
  endtask

  task automatic test_bounce();
    for (int k = 1; k <= 44; k++) begin
      btn_raw = (k <= 40) && ((k % 4) != 0);
      tick();
      checks++;
      if (obs()[7:3] !== 5'b0 || state_dbg > 3'd1) begin
        errors++;
        $display("FAIL bounce k=%0d got=%b want=level/pulses 0 state<=1", k, obs());
      end
    end
    checks++;
    if (state_dbg !== 3'd0) begin
      errors++;
      $display("FAIL bounce_idle got=%0d want=0", state_dbg);
    end
  endtask

  task automatic test_long_hold();
    logic [7:0] e;
    for (int k = 1; k <= 60; k++) begin
      btn_raw = (k <= 45);
      tick();
      if (k <= 47)      e = held_profile(k);
      else if (k < 51)  e = pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4);
      else              e = pk(1'b0, 1'b0, k == 51, 1'b0, 1'b0, 3'd0);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL long_hold k=%0d got=%b want=%b", k, obs(), e);
      end
    end
  endtask

  task automatic test_release_glitch();
    logic [7:0] e;
    for (int k = 1; k <= 55; k++) begin
      btn_raw = !(k == 38 || k == 39);
      tick();
      if (k <= 39)       e = held_profile(k);
      else if (k <= 41)  e = pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4);
      else               e = pk(1'b1, 1'b0, 1'b0, 1'b0, (k >= 43) && ((k - 43) % 5 == 0), 3'd3);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL glitch k=%0d got=%b want=%b", k, obs(), e);
      end
    end
    btn_raw = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      tick();
      if (j < 3)       e = pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3);
      else if (j < 6)  e = pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4);
      else             e = pk(1'b0, 1'b0, j == 6, 1'b0, 1'b0, 3'd0);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL glitch_release j=%0d got=%b want=%b", j, obs(), e);
      end
    end
  endtask

  task automatic test_reset_midway();
    logic [7:0] e;
    btn_raw = 1'b1;
    for (int phase = 0; phase < 2; phase++) begin
      for (int k = 1; k <= ((phase == 0) ? 4 : 28); k++) begin
        tick();
        e = held_profile(k);
        checks++;
        if (obs() !== e) begin
          errors++;
          $display("FAIL midrst_pre p=%0d k=%0d got=%b want=%b", phase, k, obs(), e);
        end
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (obs() !== 8'h00) begin
        errors++;
        $display("FAIL midrst_async p=%0d got=%b want=%b", phase, obs(), 8'h00);
      end
      #2 rst_n = 1'b1;
    end
    for (int k = 1; k <= 10; k++) begin
      tick();
      e = held_profile(k);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL midrst_repress k=%0d got=%b want=%b", k, obs(), e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_hold();
    test_release_glitch();
    test_reset_midway();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
